// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator side of a word-addressed RAM interface. Takes single or burst
// load/store requests from the CPU datapath over a valid/ready handshake and
// sequences the RAM pins. Each word gets one SETUP cycle followed by a fixed
// ACCESS window. Load words are returned as rd_valid pulses. Requests that
// fall outside the populated banks, or that would run past the end of a bank,
// are answered with a single err pulse and never reach the RAM.
//
// Parameters
//   WAIT_CYCLES  cycles mem_address/mem_rw are held in ACCESS per word (>=1)
//   NUM_BANKS    number of populated banks; bank = addr[31:24]
//   BANK_WORDS   words per bank; word index = addr[7:0]
//
// Ports
//   clk           in   1   clock, all state changes on the rising edge
//   reset         in   1   synchronous active-high reset
//   req_valid     in   1   request present
//   req_ready     out  1   high only while idle
//   req_rw        in   1   1 = store, 0 = load (sampled at handshake)
//   req_addr      in  32   start word address (sampled at handshake)
//   req_len       in   4   burst length minus one
//   wr_data       in  32   store word, sampled as SETUP ends
//   wr_pop        out  1   pulse: wr_data consumed, present the next word
//   rd_data       out 32   captured load word
//   rd_valid      out  1   pulse: rd_data valid
//   done          out  1   pulse: request finished normally
//   err           out  1   pulse: request rejected
//   busy          out  1   inverse of req_ready
//   mem_address   out 32   RAM address
//   mem_data_out  out 32   RAM write data
//   mem_rw        out  1   RAM write strobe (1 = write)
//   mem_data_in   in  32   RAM read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int NUM_BANKS   = 8,
    parameter int BANK_WORDS  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    output logic        mem_rw,
    input  logic [31:0] mem_data_in
);

    // Wait counter counts down from WAIT_CYCLES-1 to 0 inside ACCESS.
    localparam int                CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

    // Legality limits widened to 9 bits so the compare cannot wrap.
    localparam logic [8:0] NUM_BANKS_W = 9'(NUM_BANKS);
    localparam logic [8:0] LAST_WORD_W = 9'(BANK_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic             r_rw;
    logic [31:0]      r_cur_addr;
    logic [4:0]       r_words_left;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_mem_address;
    logic [31:0]      r_mem_data_out;
    logic             r_mem_rw;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_wr_pop;
    logic             r_done;
    logic             r_err;

    logic [8:0]       w_bank_ext;
    logic [8:0]       w_end_word;
    logic             w_req_legal;
    logic             w_handshake;
    logic             w_last_wait;
    logic             w_last_word;
    logic [31:0]      w_next_addr;

    // A burst is legal only when its bank exists and its final word stays in
    // the same bank, so cur_addr never carries out of addr[7:0].
    assign w_bank_ext  = {1'b0, req_addr[31:24]};
    assign w_end_word  = {1'b0, req_addr[7:0]} + {5'b0, req_len};
    assign w_req_legal = (w_bank_ext < NUM_BANKS_W) && (w_end_word <= LAST_WORD_W);
    assign w_handshake = req_valid & r_req_ready;
    assign w_last_wait = (r_wait_cnt == '0);
    assign w_last_word = (r_words_left == 5'd1);
    assign w_next_addr = r_cur_addr + 32'd1;

    // NOTE: every register below is written with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_req_ready    <= 1'b1;
            r_rw           <= 1'b0;
            r_cur_addr     <= '0;
            r_words_left   <= '0;
            r_wait_cnt     <= '0;
            r_mem_address  <= '0;
            r_mem_data_out <= '0;
            r_mem_rw       <= 1'b0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_wr_pop       <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; a state that wants
            // a pulse overrides the default later in this block.
            r_rd_valid <= 1'b0;
            r_wr_pop   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_rw         <= req_rw;
                        r_cur_addr   <= req_addr;
                        r_words_left <= {1'b0, req_len} + 5'd1;
                        r_req_ready  <= 1'b0;
                        if (w_req_legal) begin
                            // Address moves while the write strobe is low.
                            r_mem_address <= req_addr;
                            r_mem_rw      <= 1'b0;
                            r_state       <= ST_SETUP;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end

                ST_SETUP: begin
                    r_wait_cnt <= CNT_RELOAD;
                    if (r_rw) begin
                        r_mem_data_out <= wr_data;
                        r_wr_pop       <= 1'b1;
                        r_mem_rw       <= 1'b1;
                    end
                    r_state <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (w_last_wait) begin
                        // Strobe drops before any following address change.
                        r_mem_rw <= 1'b0;
                        if (!r_rw) begin
                            r_rd_data  <= mem_data_in;
                            r_rd_valid <= 1'b1;
                        end
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cur_addr    <= w_next_addr;
                            r_mem_address <= w_next_addr;
                            r_words_left  <= r_words_left - 5'd1;
                            r_state       <= ST_SETUP;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_mem_rw    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                ST_ERR: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_req_ready <= 1'b1;
                    r_mem_rw    <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign busy         = ~r_req_ready;
    assign wr_pop       = r_wr_pop;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign done         = r_done;
    assign err          = r_err;
    assign mem_address  = r_mem_address;
    assign mem_data_out = r_mem_data_out;
    assign mem_rw       = r_mem_rw;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Scoreboard bench for mem_access_ctrl. Issuing a request pushes the expected
// responses (read words with their arrival cycle, done/err with its cycle)
// into queues computed from the request rules; a monitor pops and compares
// whenever the DUT pulses rd_valid, done or err. A small RAM model sits on
// the memory pins and also audits write-strobe behaviour.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int W     = 2;
    localparam int NB    = 8;
    localparam int BW    = 256;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic        mem_rw;
    logic [31:0] mem_data_in = '0;

    mem_access_ctrl #(
        .WAIT_CYCLES(W),
        .NUM_BANKS  (NB),
        .BANK_WORDS (BW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_data     (wr_data),
        .wr_pop      (wr_pop),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_data_out(mem_data_out),
        .mem_rw      (mem_rw),
        .mem_data_in (mem_data_in)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // kind: 1 = done, 2 = err (rd events use the rd queue only)
    typedef struct {
        logic [31:0] data;
        int          t;
        int          kind;
    } ev_t;

    ev_t         rdq[$];
    ev_t         doneq[$];
    logic [31:0] wq[$];
    logic [31:0] model_mem [bit [31:0]];
    logic [31:0] ram [bit [31:0]];

    int          n_checks = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    int          rw_cycles = 0;
    int          rw_addr_bad = 0;
    int          pops_seen = 0;
    logic [31:0] cur_lo = '0;
    logic [31:0] cur_hi = '0;
    logic [31:0] prev_addr = '0;
    ev_t         mon_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    // RAM model on the memory pins, plus write-strobe audit.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_address !== prev_addr)
                check("mem_rw_on_addr_change", 32'(mem_rw), 32'h0);
            prev_addr = mem_address;
            if (mem_rw === 1'b1) begin
                rw_cycles++;
                if (mem_address < cur_lo || mem_address > cur_hi) rw_addr_bad++;
                ram[mem_address] = mem_data_out;
            end
            mem_data_in = ram.exists(mem_address) ? ram[mem_address] : 32'h0;
        end
    end

    // Store-data feeder: advance to the next word after each wr_pop.
    always @(negedge clk) begin
        if (mon_en && wr_pop === 1'b1) begin
            if (wq.size() == 0) begin
                check("wr_pop_unexpected", 32'(wr_pop), 32'h0);
            end else begin
                void'(wq.pop_front());
                pops_seen++;
                if (wq.size() > 0) wr_data = wq[0];
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (rd_valid === 1'b1) begin
                if (rdq.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'h0);
                end else begin
                    mon_ev = rdq.pop_front();
                    check("rd_data", rd_data, mon_ev.data);
                    check("rd_time", 32'(edge_cnt), 32'(mon_ev.t));
                end
            end
            if (done === 1'b1) begin
                if (doneq.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'h0);
                end else begin
                    mon_ev = doneq.pop_front();
                    check("done_kind", 32'h1, 32'(mon_ev.kind));
                    check("done_time", 32'(edge_cnt), 32'(mon_ev.t));
                end
            end
            if (err === 1'b1) begin
                if (doneq.size() == 0) begin
                    check("err_unexpected", 32'(err), 32'h0);
                end else begin
                    mon_ev = doneq.pop_front();
                    check("err_kind", 32'h2, 32'(mon_ev.kind));
                    check("err_time", 32'(edge_cnt), 32'(mon_ev.t));
                end
            end
            if (rdq.size() > 0 && rdq[0].t < edge_cnt) begin
                check("rd_valid_missing", 32'(edge_cnt), 32'(rdq[0].t));
                void'(rdq.pop_front());
            end
            if (doneq.size() > 0 && doneq[0].t < edge_cnt) begin
                check("done_err_missing", 32'(edge_cnt), 32'(doneq[0].t));
                void'(doneq.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("ready_budget_exceeded", 32'(n >= LIMIT), 32'h0);
    endtask

    // Issue one request; keep_words < len+1 models a burst cut short by reset.
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] d0, input bit incr, input int keep_words,
                         output int t, output bit legal);
        logic [31:0] d;
        wait_ready();
        t     = edge_cnt + 1;
        legal = (int'(addr[31:24]) < NB) && (int'(addr[7:0]) + int'(len) <= BW - 1);
        rw_cycles   = 0;
        rw_addr_bad = 0;
        pops_seen   = 0;
        cur_lo      = addr;
        cur_hi      = addr + 32'(len);
        if (!legal) begin
            doneq.push_back('{data: 32'h0, t: t, kind: 2});
            wr_data = $urandom;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                if (rw) begin
                    d = incr ? d0 + 32'(i) : ((i == 0) ? d0 : $urandom);
                    wq.push_back(d);
                    model_mem[addr + 32'(i)] = d;
                end else if (i < keep_words) begin
                    rdq.push_back('{data: model_rd(addr + 32'(i)),
                                    t: t + 1 + W + i * (1 + W), kind: 0});
                end
            end
            if (keep_words == int'(len) + 1)
                doneq.push_back('{data: 32'h0, t: t + (int'(len) + 1) * (1 + W), kind: 1});
            if (wq.size() > 0) wr_data = wq[0];
        end
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = 1'(($urandom));
        req_addr  = $urandom;
        req_len   = 4'($urandom);
    endtask

    task automatic wait_done(input logic rw, input logic [3:0] len, input bit legal);
        int n = 0;
        while ((rdq.size() != 0 || doneq.size() != 0 || req_ready !== 1'b1) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("done_budget_exceeded", 32'(n >= LIMIT), 32'h0);
        if (n >= LIMIT) begin
            rdq.delete();
            doneq.delete();
            wq.delete();
        end
        check("mem_rw_cycles", 32'(rw_cycles), (legal && rw) ? 32'((int'(len) + 1) * W) : 32'h0);
        check("wr_pop_count", 32'(pops_seen), (legal && rw) ? 32'(int'(len) + 1) : 32'h0);
        check("mem_rw_addr_range", 32'(rw_addr_bad), 32'h0);
    endtask

    task automatic run_req(input logic rw, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] d0, input bit incr);
        int t;
        bit legal;
        issue(rw, addr, len, d0, incr, int'(len) + 1, t, legal);
        wait_done(rw, len, legal);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_data_out", mem_data_out, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_mem_rw", 32'(mem_rw), 32'h0);
        check("rst_wr_pop", 32'(wr_pop), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
    endtask

    initial begin
        int t;
        bit legal;
        int pulses;
        logic [7:0] bank;
        logic [7:0] idx;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset     = 1'b0;
        prev_addr = mem_address;
        mon_en    = 1'b1;

        // Single store, then read it back.
        run_req(1'b1, 32'h0100_0005, 4'd0, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b0, 32'h0100_0005, 4'd0, 32'h0, 1'b0);

        // Burst store of 1..4 ending on the last word of the bank, read back.
        run_req(1'b1, 32'h0300_00FC, 4'd3, 32'h1, 1'b1);
        run_req(1'b0, 32'h0300_00FC, 4'd3, 32'h0, 1'b0);

        // Bank 8 does not exist: err one cycle after handshake, ready after that.
        issue(1'b1, 32'h0800_0000, 4'd0, 32'h1234_5678, 1'b0, 1, t, legal);
        check("err_cycle_ready", 32'(req_ready), 32'h0);
        check("err_cycle_err", 32'(err), 32'h1);
        @(negedge clk);
        check("err_ready_back", 32'(req_ready), 32'h1);
        wait_done(1'b1, 4'd0, legal);

        // Burst that would cross into the next bank is rejected.
        run_req(1'b0, 32'h0000_00FE, 4'd2, 32'h0, 1'b0);
        // Largest legal bank with a burst ending exactly at word 255.
        run_req(1'b1, 32'h0700_00F0, 4'd15, 32'hA000_0000, 1'b1);
        run_req(1'b0, 32'h0700_00F0, 4'd15, 32'h0, 1'b0);

        // Reset during the ACCESS window of word 2 of a 4-word load.
        issue(1'b0, 32'h0300_00FC, 4'd3, 32'h0, 1'b0, 1, t, legal);
        repeat (4) @(negedge clk);
        check("abort_in_access_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        check("abort_rd_queue_drained", 32'(rdq.size()), 32'h0);
        reset  = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (rd_valid === 1'b1 || done === 1'b1 || err === 1'b1) pulses++;
        end
        check("abort_no_late_pulses", 32'(pulses), 32'h0);
        run_req(1'b0, 32'h0300_00FE, 4'd1, 32'h0, 1'b0);

        // Randomised mix, including illegal banks and bank-crossing bursts.
        for (int k = 0; k < 40; k++) begin
            bank = 8'($urandom_range(0, 9));
            idx  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                                : 8'($urandom_range(0, 20));
            run_req(1'($urandom_range(0, 1)), {bank, 16'h0000, idx},
                    4'($urandom_range(0, 15)), $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
